// File: rtl/naive_bus_arb_pkg.sv
// Shared types, widths and helpers for the naive_bus round-robin arbiter.
// Bus field widths are fixed here so every master/slave port agrees.
package naive_bus_arb_pkg;

  localparam int MAX_MASTER = 8;
  localparam int IDX_W      = 3;
  localparam int OWN_W      = IDX_W + 1;
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  typedef logic [IDX_W-1:0] arb_idx_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Rotate a priority pointer one step, wrapping at n.
  function automatic arb_idx_t rr_next(input arb_idx_t ptr, input int n);
    arb_idx_t nxt;
    if ((int'(ptr) + 1) >= n) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = ptr + arb_idx_t'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/naive_bus_rr_chk.sv
// Protocol checker for one arbitration channel: a locked owner must keep
// its request up until the slave grants it.
module naive_bus_rr_chk
  import naive_bus_arb_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_MASTER-1:0] req,
  input  logic                locked,
  input  arb_idx_t            sel
);

  logic [MAX_MASTER-1:0] req_ext;
  logic                  owner_req;

  assign req_ext   = MAX_MASTER'(req);
  assign owner_req = req_ext[sel];

  a_owner_holds_req: assert property (
    @(posedge clk) disable iff (!rst_n) locked |-> owner_req
  );

endmodule

// File: rtl/naive_bus_rr_pick.sv
// One channel of the round-robin arbiter: rotating-priority scan plus the
// ptr/lock/sel state that keeps a stalled selection stable.
module naive_bus_rr_pick
  import naive_bus_arb_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_MASTER-1:0] req,
  input  logic                gnt,
  output arb_idx_t            win_idx,
  output logic                win_vld
);

  arb_state_t            state_q, state_d;
  arb_idx_t              ptr_q, ptr_d;
  arb_idx_t              sel_q, sel_d;
  arb_idx_t              scan_idx;
  logic                  scan_vld;
  logic [MAX_MASTER-1:0] req_ext;

  assign req_ext = MAX_MASTER'(req);

  // Scan from ptr upward; walking offsets backwards lets the nearest requester win last.
  always_comb begin
    scan_idx = {IDX_W{1'b0}};
    scan_vld = 1'b0;
    for (int off = N_MASTER - 1; off >= 0; off--) begin
      logic [OWN_W-1:0] sum;
      logic [OWN_W-1:0] cand;
      sum  = {1'b0, ptr_q} + OWN_W'(off);
      cand = (sum >= OWN_W'(N_MASTER)) ? (sum - OWN_W'(N_MASTER)) : sum;
      if (req_ext[cand[IDX_W-1:0]]) begin
        scan_idx = cand[IDX_W-1:0];
        scan_vld = 1'b1;
      end else begin
        scan_idx = scan_idx;
        scan_vld = scan_vld;
      end
    end
  end

  // Winner selection, lock state transitions and pointer rotation.
  always_comb begin
    win_idx = scan_idx;
    win_vld = scan_vld;
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (scan_vld && !gnt) begin
          state_d = ARB_LOCKED;
          sel_d   = scan_idx;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        win_idx = sel_q;
        win_vld = 1'b1;
        if (gnt) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_LOCKED;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    if (win_vld && gnt) begin
      ptr_d = rr_next(win_idx, N_MASTER);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      ptr_q   <= {IDX_W{1'b0}};
      sel_q   <= {IDX_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  naive_bus_rr_chk #(
    .N_MASTER (N_MASTER)
  ) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .locked (state_q == ARB_LOCKED),
    .sel    (sel_q)
  );

endmodule

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave among N_MASTER masters.
// Read and write channels arbitrate independently; read beats return to the granted master.
module naive_bus_rr_arbiter
  import naive_bus_arb_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // Master side, one field slice per requester (index i at [i*W +: W]).
  input  logic [N_MASTER-1:0]            m_rd_req,
  input  logic [N_MASTER*BUS_BE_W-1:0]   m_rd_be,
  input  logic [N_MASTER*BUS_ADDR_W-1:0] m_rd_addr,
  output logic [N_MASTER-1:0]            m_rd_gnt,
  output logic [N_MASTER*BUS_DATA_W-1:0] m_rd_data,
  input  logic [N_MASTER-1:0]            m_wr_req,
  input  logic [N_MASTER*BUS_BE_W-1:0]   m_wr_be,
  input  logic [N_MASTER*BUS_ADDR_W-1:0] m_wr_addr,
  input  logic [N_MASTER*BUS_DATA_W-1:0] m_wr_data,
  output logic [N_MASTER-1:0]            m_wr_gnt,
  // Shared slave side.
  output logic                           s_rd_req,
  output logic [BUS_BE_W-1:0]            s_rd_be,
  output logic [BUS_ADDR_W-1:0]          s_rd_addr,
  input  logic                           s_rd_gnt,
  input  logic [BUS_DATA_W-1:0]          s_rd_data,
  output logic                           s_wr_req,
  output logic [BUS_BE_W-1:0]            s_wr_be,
  output logic [BUS_ADDR_W-1:0]          s_wr_addr,
  output logic [BUS_DATA_W-1:0]          s_wr_data,
  input  logic                           s_wr_gnt
);

  localparam logic [OWN_W-1:0] OWNER_NONE = OWN_W'(N_MASTER);

  arb_idx_t         rd_idx, wr_idx;
  logic             rd_vld, wr_vld;
  logic [OWN_W-1:0] rd_owner_q, rd_owner_d;

  naive_bus_rr_pick #(
    .N_MASTER (N_MASTER)
  ) u_rd_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (m_rd_req),
    .gnt     (s_rd_gnt),
    .win_idx (rd_idx),
    .win_vld (rd_vld)
  );

  naive_bus_rr_pick #(
    .N_MASTER (N_MASTER)
  ) u_wr_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (m_wr_req),
    .gnt     (s_wr_gnt),
    .win_idx (wr_idx),
    .win_vld (wr_vld)
  );

  // Read request mux and grant demux; AND-OR so an absent winner drives zeros.
  always_comb begin
    s_rd_req  = 1'b0;
    s_rd_be   = {BUS_BE_W{1'b0}};
    s_rd_addr = {BUS_ADDR_W{1'b0}};
    m_rd_gnt  = {N_MASTER{1'b0}};
    for (int i = 0; i < N_MASTER; i++) begin
      logic hit;
      hit         = rd_vld && (rd_idx == arb_idx_t'(i));
      s_rd_req    = s_rd_req  | (m_rd_req[i] & hit);
      s_rd_be     = s_rd_be   | (m_rd_be[i*BUS_BE_W +: BUS_BE_W] & {BUS_BE_W{hit}});
      s_rd_addr   = s_rd_addr | (m_rd_addr[i*BUS_ADDR_W +: BUS_ADDR_W] & {BUS_ADDR_W{hit}});
      m_rd_gnt[i] = s_rd_gnt & hit;
    end
  end

  // Write request mux and grant demux.
  always_comb begin
    s_wr_req  = 1'b0;
    s_wr_be   = {BUS_BE_W{1'b0}};
    s_wr_addr = {BUS_ADDR_W{1'b0}};
    s_wr_data = {BUS_DATA_W{1'b0}};
    m_wr_gnt  = {N_MASTER{1'b0}};
    for (int i = 0; i < N_MASTER; i++) begin
      logic hit;
      hit         = wr_vld && (wr_idx == arb_idx_t'(i));
      s_wr_req    = s_wr_req  | (m_wr_req[i] & hit);
      s_wr_be     = s_wr_be   | (m_wr_be[i*BUS_BE_W +: BUS_BE_W] & {BUS_BE_W{hit}});
      s_wr_addr   = s_wr_addr | (m_wr_addr[i*BUS_ADDR_W +: BUS_ADDR_W] & {BUS_ADDR_W{hit}});
      s_wr_data   = s_wr_data | (m_wr_data[i*BUS_DATA_W +: BUS_DATA_W] & {BUS_DATA_W{hit}});
      m_wr_gnt[i] = s_wr_gnt & hit;
    end
  end

  // Remember who owns the read beat arriving next cycle.
  always_comb begin
    if (rd_vld && s_rd_gnt) begin
      rd_owner_d = {1'b0, rd_idx};
    end else begin
      rd_owner_d = OWNER_NONE;
    end
  end

  // Read-data steering register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= OWNER_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Return read data only to the owning master.
  always_comb begin
    m_rd_data = {(N_MASTER*BUS_DATA_W){1'b0}};
    for (int i = 0; i < N_MASTER; i++) begin
      m_rd_data[i*BUS_DATA_W +: BUS_DATA_W] =
        s_rd_data & {BUS_DATA_W{rd_owner_q == OWN_W'(i)}};
    end
  end

endmodule

// File: tb/tb_naive_bus_rr_arbiter.sv
// Self-checking bench for naive_bus_rr_arbiter (N_MASTER=3): directed scenarios
// plus randomized traffic compared against a cycle-level reference model.
module tb_naive_bus_rr_arbiter;
  import naive_bus_arb_pkg::*;

  localparam int NM    = 3;
  localparam int AW    = BUS_ADDR_W;
  localparam int DW    = BUS_DATA_W;
  localparam int BW    = BUS_BE_W;
  localparam int SRD_W = 1 + BW + AW;
  localparam int SWR_W = 1 + BW + AW + DW;

  logic clk = 1'b0;
  logic rst_n;

  logic [NM-1:0]    m_rd_req;
  logic [NM*BW-1:0] m_rd_be;
  logic [NM*AW-1:0] m_rd_addr;
  logic [NM-1:0]    m_rd_gnt;
  logic [NM*DW-1:0] m_rd_data;
  logic [NM-1:0]    m_wr_req;
  logic [NM*BW-1:0] m_wr_be;
  logic [NM*AW-1:0] m_wr_addr;
  logic [NM*DW-1:0] m_wr_data;
  logic [NM-1:0]    m_wr_gnt;
  logic             s_rd_req;
  logic [BW-1:0]    s_rd_be;
  logic [AW-1:0]    s_rd_addr;
  logic             s_rd_gnt;
  logic [DW-1:0]    s_rd_data;
  logic             s_wr_req;
  logic [BW-1:0]    s_wr_be;
  logic [AW-1:0]    s_wr_addr;
  logic [DW-1:0]    s_wr_data;
  logic             s_wr_gnt;

  naive_bus_rr_arbiter #(.N_MASTER(NM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_rd_req(m_rd_req), .m_rd_be(m_rd_be), .m_rd_addr(m_rd_addr),
    .m_rd_gnt(m_rd_gnt), .m_rd_data(m_rd_data),
    .m_wr_req(m_wr_req), .m_wr_be(m_wr_be), .m_wr_addr(m_wr_addr),
    .m_wr_data(m_wr_data), .m_wr_gnt(m_wr_gnt),
    .s_rd_req(s_rd_req), .s_rd_be(s_rd_be), .s_rd_addr(s_rd_addr),
    .s_rd_gnt(s_rd_gnt), .s_rd_data(s_rd_data),
    .s_wr_req(s_wr_req), .s_wr_be(s_wr_be), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .s_wr_gnt(s_wr_gnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: pointers, locked owner (-1 none), read-beat owner (-1 none).
  int rd_ptr, wr_ptr, rd_own, wr_own, rd_ret;
  int rw, ww;
  logic [NM-1:0]    g_rd, g_wr;
  logic             beat_vld;
  logic [AW-1:0]    beat_addr;
  logic [NM-1:0]    obs_rd_gnt, obs_wr_gnt;
  logic [NM*DW-1:0] obs_rd_data;
  logic [SRD_W-1:0] obs_srd;
  logic [SWR_W-1:0] obs_swr;
  logic [AW-1:0]    prev_addr;
  int               order [4] = '{2, 0, 1, 2};

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] tag_of(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // First requester at or after ptr in rotation order, or the locked owner.
  function automatic int pick(input int ptr, input int own, input logic [NM-1:0] req);
    if (own >= 0) return own;
    for (int k = 0; k < NM; k++) begin
      if (req[(ptr + k) % NM]) return (ptr + k) % NM;
    end
    return -1;
  endfunction

  // One bus cycle: drive slave data, compare all outputs, advance the model.
  task automatic step();
    logic [NM-1:0]    exp_rg, exp_wg;
    logic [SRD_W-1:0] exp_srd;
    logic [SWR_W-1:0] exp_swr;
    logic [NM*DW-1:0] exp_rdata;
    s_rd_data = beat_vld ? tag_of(beat_addr) : DW'($urandom);
    #1;
    if (!rst_n) begin
      rd_ptr = 0; wr_ptr = 0; rd_own = -1; wr_own = -1; rd_ret = -1;
    end
    rw = pick(rd_ptr, rd_own, m_rd_req);
    ww = pick(wr_ptr, wr_own, m_wr_req);
    exp_rg = '0; exp_wg = '0; exp_srd = '0; exp_swr = '0; exp_rdata = '0;
    if (rw >= 0) begin
      exp_srd    = {m_rd_req[rw], m_rd_be[rw*BW +: BW], m_rd_addr[rw*AW +: AW]};
      exp_rg[rw] = s_rd_gnt;
    end
    if (ww >= 0) begin
      exp_swr    = {m_wr_req[ww], m_wr_be[ww*BW +: BW], m_wr_addr[ww*AW +: AW],
                    m_wr_data[ww*DW +: DW]};
      exp_wg[ww] = s_wr_gnt;
    end
    if (rd_ret >= 0) exp_rdata[rd_ret*DW +: DW] = s_rd_data;
    obs_srd     = {s_rd_req, s_rd_be, s_rd_addr};
    obs_swr     = {s_wr_req, s_wr_be, s_wr_addr, s_wr_data};
    obs_rd_gnt  = m_rd_gnt;
    obs_wr_gnt  = m_wr_gnt;
    obs_rd_data = m_rd_data;
    check_eq("slv_rd",  128'(obs_srd),     128'(exp_srd));
    check_eq("slv_wr",  128'(obs_swr),     128'(exp_swr));
    check_eq("rd_gnt",  128'(obs_rd_gnt),  128'(exp_rg));
    check_eq("wr_gnt",  128'(obs_wr_gnt),  128'(exp_wg));
    check_eq("rd_data", 128'(obs_rd_data), 128'(exp_rdata));
    g_rd = exp_rg;
    g_wr = exp_wg;
    @(posedge clk);
    if (rst_n) begin
      if (rw >= 0 && s_rd_gnt) begin
        rd_ptr = (rw + 1) % NM; rd_own = -1; rd_ret = rw;
      end else begin
        rd_own = rw; rd_ret = -1;
      end
      if (ww >= 0 && s_wr_gnt) begin
        wr_ptr = (ww + 1) % NM; wr_own = -1;
      end else begin
        wr_own = ww;
      end
      beat_vld  = (exp_rg != '0);
      beat_addr = exp_srd[AW-1:0];
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m_rd_req = '0; m_rd_be = '0; m_rd_addr = '0;
    m_wr_req = '0; m_wr_be = '0; m_wr_addr = '0; m_wr_data = '0;
    s_rd_gnt = 1'b0; s_wr_gnt = 1'b0; s_rd_data = '0;
    rd_ptr = 0; wr_ptr = 0; rd_own = -1; wr_own = -1; rd_ret = -1;
    g_rd = '0; g_wr = '0; beat_vld = 1'b0; beat_addr = '0; prev_addr = '0;

    // Reset state: nothing requested, nothing granted, no read data.
    @(negedge clk);
    step();
    check_eq("rst_quiet", 128'({obs_rd_gnt, obs_wr_gnt, obs_rd_data}), 128'(0));
    step();
    rst_n = 1'b1;

    // Two masters reading back to back: alternating grants, tagged data one cycle later.
    s_rd_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_rd_req[i] || g_rd[i]) begin
          m_rd_req[i] = 1'b1;
          m_rd_be[i*BW +: BW] = 4'hF;
          m_rd_addr[i*AW +: AW] = {8'(i), 8'(c), 16'h0000};
        end
      end
      step();
      check_eq("rr_alt", 128'(obs_rd_gnt), 128'(3'b001 << (c % 2)));
      if (c > 0) check_eq("rd_tag", 128'(obs_rd_data[((c - 1) % 2)*DW +: DW]), 128'(tag_of(prev_addr)));
      prev_addr = m_rd_addr[(c % 2)*AW +: AW];
    end

    // Three readers with ptr at 2: order 2,0,1,2 with wrap.
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_rd_req[i] || g_rd[i]) begin
          m_rd_req[i] = 1'b1;
          m_rd_addr[i*AW +: AW] = {8'(i), 8'(c + 8), 16'h0004};
        end
      end
      step();
      check_eq("rr_wrap", 128'(obs_rd_gnt), 128'(3'b001 << order[c]));
    end
    m_rd_req = '0;

    // Stalled write from M1 keeps the slave locked while M0 waits.
    m_wr_addr[1*AW +: AW] = 32'h1000_0010;
    m_wr_data[1*DW +: DW] = 32'hDEAD_0001;
    m_wr_addr[0*AW +: AW] = 32'h0000_0020;
    m_wr_data[0*DW +: DW] = 32'hBEEF_0000;
    for (int c = 0; c < 5; c++) begin
      m_wr_req[1] = (c < 4);
      m_wr_req[0] = (c >= 1);
      s_wr_gnt    = (c >= 3);
      step();
      check_eq("lock_addr", 128'(obs_swr[AW+DW-1:DW]), 128'((c < 4) ? 32'h1000_0010 : 32'h0000_0020));
      check_eq("lock_gnt", 128'(obs_wr_gnt), 128'((c == 3) ? 3'b010 : ((c == 4) ? 3'b001 : 3'b000)));
    end
    m_wr_req = '0;

    // Read and write channels grant independently in the same cycle.
    m_rd_req = 3'b001; m_wr_req = 3'b010;
    step();
    check_eq("indep_rd0", 128'(obs_rd_gnt), 128'(3'b001));
    check_eq("indep_wr0", 128'(obs_wr_gnt), 128'(3'b010));
    m_rd_req = 3'b011; m_wr_req = 3'b011;
    step();
    check_eq("indep_rd1", 128'(obs_rd_gnt), 128'(3'b010));
    check_eq("indep_wr1", 128'(obs_wr_gnt), 128'(3'b001));
    m_rd_req = '0; m_wr_req = '0;

    // Reset right after a read grant to M1, with a write lock pending on M2.
    m_rd_req = 3'b010; m_rd_addr[1*AW +: AW] = 32'h0100_0040;
    m_wr_req = 3'b100; m_wr_addr[2*AW +: AW] = 32'h0200_0080;
    s_wr_gnt = 1'b0;
    step();
    check_eq("pre_rst_gnt", 128'(obs_rd_gnt), 128'(3'b010));
    rst_n = 1'b0; m_rd_req = '0; m_wr_req = '0;
    step();
    check_eq("rst_rdata0", 128'(obs_rd_data), 128'(0));
    step();
    check_eq("rst_rdata1", 128'(obs_rd_data), 128'(0));
    rst_n = 1'b1;
    m_rd_req = 3'b111; m_wr_req = 3'b001; s_wr_gnt = 1'b1;
    step();
    check_eq("post_rst_rdata", 128'(obs_rd_data), 128'(0));
    check_eq("post_rst_ptr", 128'(obs_rd_gnt), 128'(3'b001));
    check_eq("post_rst_lock", 128'(obs_wr_gnt), 128'(3'b001));
    m_rd_req = '0; m_wr_req = '0;

    // Idle cycles leave the slave quiet and the pointer untouched.
    for (int c = 0; c < 5; c++) begin
      s_rd_gnt = 1'($urandom_range(0, 1));
      s_wr_gnt = 1'($urandom_range(0, 1));
      step();
      check_eq("idle_out", 128'({obs_srd, obs_rd_gnt, obs_wr_gnt}), 128'(0));
    end
    m_rd_req = 3'b111; s_rd_gnt = 1'b1;
    step();
    check_eq("idle_ptr", 128'(obs_rd_gnt), 128'(3'b010));
    m_rd_req = '0;

    // Randomized traffic against the model; masters hold requests until granted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_rd_req[i] || g_rd[i]) begin
          m_rd_req[i] = ($urandom_range(0, 99) < 55);
          m_rd_be[i*BW +: BW] = BW'($urandom);
          m_rd_addr[i*AW +: AW] = {8'(i), 24'($urandom)};
        end
        if (!m_wr_req[i] || g_wr[i]) begin
          m_wr_req[i] = ($urandom_range(0, 99) < 50);
          m_wr_be[i*BW +: BW] = BW'($urandom);
          m_wr_addr[i*AW +: AW] = {8'(i + 16), 24'($urandom)};
          m_wr_data[i*DW +: DW] = DW'($urandom);
        end
      end
      s_rd_gnt = ($urandom_range(0, 99) < 60);
      s_wr_gnt = ($urandom_range(0, 99) < 60);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
